// File: rtl/key_exp_inv.sv
// Inverse AES-128 key schedule: walks round keys from the last round down to the
// cipher key, one key per valid/ready handshake.
module key_exp_inv #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] last_key,
  input  logic         key_ready,
  output logic [0:127] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold last values, key_valid=0
  // EMIT  | presenting round_key/round_idx, stepping back one round per handshake
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [0:31]  k0, k1, k2, k3;
  logic [0:31]  p0, p1, p2, p3;
  logic [0:31]  sub_rot;
  logic [0:127] prev_key;

  assign k0 = round_key[0:31];
  assign k1 = round_key[32:63];
  assign k2 = round_key[64:95];
  assign k3 = round_key[96:127];

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // SubWord(RotWord(p3)): byte 0 rotates to the end before substitution
  assign sub_rot = {SBOX[p3[8:15]], SBOX[p3[16:23]], SBOX[p3[24:31]], SBOX[p3[0:7]]};
  assign p0 = k0 ^ sub_rot ^ {rcon(round_idx), 24'h000000};

  assign prev_key = {p0, p1, p2, p3};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= EMIT;
            round_key <= last_key;
            round_idx <= NR[3:0];
            key_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (round_idx == 4'd0) begin
              state     <= IDLE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              round_key <= prev_key;
              round_idx <= round_idx - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_exp_inv.sv
// Scoreboard bench for key_exp_inv: a reference model derives every round key by
// undoing the forward AES-128 expansion word by word.
module tb_key_exp_inv;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] last_key = '0;
  logic         key_ready = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  key_exp_inv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] FIPS_9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] FIPS_1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ZERO_10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
  localparam logic [127:0] ZERO_1  = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] KEY_B   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_C   = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  bit           exp_done = 1'b0;
  int           mode = 0;
  int           rcyc = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rc [1:10];
  logic [127:0] mk [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  task automatic init_tables();
    logic [7:0] y;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(x[7:0], c[7:0]) == 8'h01) y = c[7:0];
      sb[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    end
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = gmul(rc[i-1], 8'h02);
  endtask

  // Forward rule w[i+4] = w[i] ^ f(w[i+3]) solved for w[i], walking down from word 43
  task automatic build(input logic [127:0] lk);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40+j] = lk[127-32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if ((i + 4) % 4 == 0)
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc[(i+4)/4], 24'h000000};
      w[i] = w[i+4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_mk();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.idx = r[3:0];
      e.key = mk[r];
      q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [127:0] k);
    @(posedge clk); #1;
    last_key = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    case (mode)
      0: key_ready = 1'b1;
      1: begin key_ready = (rcyc % 3 == 0); rcyc++; end
      default: key_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("done", 128'(done), 128'(exp_done));
      exp_done = 1'b0;
      if (key_valid) begin
        chk("busy", 128'(busy), 128'(1'b1));
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key got idx %0d exp none", round_idx);
        end else begin
          chk("round_idx", 128'(round_idx), 128'(q[0].idx));
          chk("round_key", round_key, q[0].key);
          if (key_ready) begin
            if (q[0].idx == 4'd0) exp_done = 1'b1;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("busy_idle", 128'(busy), 128'(1'b0));
      end
    end
  end

  initial begin
    int n;
    logic [127:0] k;
    init_tables();

    // reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    last_key = FIPS_10;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 128'(key_valid), 128'(1'b0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_done", 128'(done), 128'(1'b0));
      chk("rst_key", round_key, 128'h0);
      chk("rst_idx", 128'(round_idx), 128'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    mon_en = 1'b1;

    // FIPS-197 vector, always ready
    mode = 0;
    build(FIPS_10);
    mk[9] = FIPS_9; mk[1] = FIPS_1; mk[0] = FIPS_0;
    push_mk();
    pulse_start(FIPS_10);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("cycles_to_done", 128'(n), 128'(12));
    wait_drain();

    // key whose round 0 is all zero
    build(ZERO_10);
    mk[1] = ZERO_1; mk[0] = 128'h0;
    push_mk();
    pulse_start(ZERO_10);
    wait_drain();

    // back-pressure pattern 1,0,0
    mode = 1;
    rcyc = 0;
    build(FIPS_10);
    mk[9] = FIPS_9; mk[1] = FIPS_1; mk[0] = FIPS_0;
    push_mk();
    pulse_start(FIPS_10);
    wait_drain();

    // start while busy (idx 5 and final handshake) ignored; start in done cycle taken
    mode = 0;
    build(FIPS_10);
    push_mk();
    pulse_start(FIPS_10);
    repeat (5) @(posedge clk);
    #1;
    last_key = KEY_B;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    build(KEY_C);
    push_mk();
    last_key = KEY_C;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // reset for one edge while idx 4 is presented
    build(FIPS_10);
    push_mk();
    pulse_start(FIPS_10);
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    exp_done = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 128'(key_valid), 128'(1'b0));
    chk("mid_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_rst_done", 128'(done), 128'(1'b0));
    chk("mid_rst_key", round_key, 128'h0);
    chk("mid_rst_idx", 128'(round_idx), 128'h0);
    @(negedge clk);
    chk("mid_rst_no_done", 128'(done), 128'(1'b0));
    mon_en = 1'b1;
    build(FIPS_10);
    mk[0] = FIPS_0;
    push_mk();
    pulse_start(FIPS_10);
    wait_drain();

    // random keys under random back-pressure
    mode = 2;
    for (int t = 0; t < 6; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      build(k);
      push_mk();
      pulse_start(k);
      wait_drain();
    end

    chk("final_idle", 128'(key_valid), 128'(1'b0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
